// File: rtl/micro_sequencer_pkg.sv
// Shared types and field layout for the Mic-1 style micro-sequencer.
package micro_sequencer_pkg;
  localparam int MPC_BITS   = 9;
  localparam int MIR_BITS   = 36;
  localparam int ALU_BITS   = 6;
  localparam int SHIFT_BITS = 2;
  localparam int CEN_BITS   = 9;
  localparam int MEM_BITS   = 3;
  localparam int BSEL_BITS  = 4;
  localparam int MBR_BITS   = 8;

  // Bit positions inside the mem field.
  localparam int MEM_FETCH = 0;
  localparam int MEM_READ  = 1;
  localparam int MEM_WRITE = 2;

  typedef enum logic [1:0] {FETCH, EXEC, MEMW, HALT} seq_state_t;

  // MSB-first microinstruction layout.
  typedef struct packed {
    logic [MPC_BITS-1:0]   addr;
    logic                  jmpc;
    logic                  jamn;
    logic                  jamz;
    logic [SHIFT_BITS-1:0] shift;
    logic [ALU_BITS-1:0]   alu_control;
    logic [CEN_BITS-1:0]   c_en;
    logic [MEM_BITS-1:0]   mem;
    logic [BSEL_BITS-1:0]  b_sel;
  } mir_t;

  function automatic logic mem_active(input logic [MEM_BITS-1:0] mem);
    return mem[MEM_WRITE] | mem[MEM_READ] | mem[MEM_FETCH];
  endfunction
endpackage

// File: rtl/micro_sequencer_if.sv
// Control-store and datapath bus of the micro-sequencer.
interface micro_sequencer_if;
  import micro_sequencer_pkg::*;

  logic [MPC_BITS-1:0]   cs_addr;
  logic [MIR_BITS-1:0]   cs_word;
  logic                  alu_n;
  logic                  alu_z;
  logic [MBR_BITS-1:0]   mbr;
  logic                  mem_ready;
  logic [ALU_BITS-1:0]   alu_control;
  logic [SHIFT_BITS-1:0] shift;
  logic [CEN_BITS-1:0]   c_en;
  logic [BSEL_BITS-1:0]  b_sel;
  logic [MEM_BITS-1:0]   mem_op;
  logic                  mem_req;
  logic                  n_flag;
  logic                  z_flag;
  logic                  halted;

  modport master (
    input  cs_word, alu_n, alu_z, mbr, mem_ready,
    output cs_addr, alu_control, shift, c_en, b_sel, mem_op, mem_req,
           n_flag, z_flag, halted
  );

  modport slave (
    output cs_word, alu_n, alu_z, mbr, mem_ready,
    input  cs_addr, alu_control, shift, c_en, b_sel, mem_op, mem_req,
           n_flag, z_flag, halted
  );
endinterface

// File: rtl/micro_sequencer_next_address.sv
// Combinational next-MPC: JAMN/JAMZ OR into bit 8, JMPC ORs MBR into the low byte.
module micro_sequencer_next_address
  import micro_sequencer_pkg::*;
(
  input  logic [MPC_BITS-1:0] addr,
  input  logic                jmpc,
  input  logic                jamn,
  input  logic                jamz,
  input  logic                alu_n,
  input  logic                alu_z,
  input  logic [MBR_BITS-1:0] mbr,
  output logic [MPC_BITS-1:0] next_addr
);
  logic                hi;
  logic [MBR_BITS-1:0] lo;

  assign hi        = addr[MPC_BITS-1] | (jamn & alu_n) | (jamz & alu_z);
  assign lo        = addr[MBR_BITS-1:0] | (jmpc ? mbr : '0);
  assign next_addr = {hi, lo};
endmodule

// File: rtl/micro_sequencer.sv
// Micro-sequencer: FETCH loads MIR from the control store, EXEC drives the
// datapath and steps MPC, MEMW holds until memory completes, HALT parks.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter logic [MPC_BITS-1:0] RESET_ADDR = 9'h000,
  parameter logic [MPC_BITS-1:0] HALT_ADDR  = 9'h1FF
) (
  input  logic               clk,
  input  logic               reset,
  micro_sequencer_if.master  bus
);
  seq_state_t          state, state_nxt;
  mir_t                mir;
  logic [MPC_BITS-1:0] mpc, mpc_nxt;
  logic                n_q, z_q;
  logic                mem_on;

  assign mem_on = mem_active(mir.mem);

  micro_sequencer_next_address u_next (
    .addr      (mir.addr),
    .jmpc      (mir.jmpc),
    .jamn      (mir.jamn),
    .jamz      (mir.jamz),
    .alu_n     (bus.alu_n),
    .alu_z     (bus.alu_z),
    .mbr       (bus.mbr),
    .next_addr (mpc_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   state_nxt = (mpc == HALT_ADDR) ? HALT : EXEC;
      // A ready already present in EXEC skips the wait state entirely.
      EXEC:    state_nxt = (mem_on && !bus.mem_ready) ? MEMW : FETCH;
      MEMW:    if (bus.mem_ready) state_nxt = FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mir <= '0;
      mpc <= RESET_ADDR;
      n_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      if (state == FETCH && mpc != HALT_ADDR) mir <= bus.cs_word;
      if (state == EXEC) begin
        mpc <= mpc_nxt;
        n_q <= bus.alu_n;
        z_q <= bus.alu_z;
      end
    end
  end

  always_comb begin
    bus.c_en    = '0;
    bus.mem_req = 1'b0;
    bus.halted  = 1'b0;
    case (state)
      EXEC: begin
        bus.c_en    = mir.c_en;
        bus.mem_req = mem_on;
      end
      MEMW:    bus.mem_req = mem_on;
      HALT:    bus.halted  = 1'b1;
      default: ;
    endcase
  end

  assign bus.cs_addr     = mpc;
  assign bus.alu_control = mir.alu_control;
  assign bus.shift       = mir.shift;
  assign bus.b_sel       = mir.b_sel;
  assign bus.mem_op      = mir.mem;
  assign bus.n_flag      = n_q;
  assign bus.z_flag      = z_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench: an instruction-level model queues the expected outputs of
// every cycle; a monitor compares them against the DUT on the falling edge.
module tb_micro_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  micro_sequencer_if bus();
  micro_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  logic [35:0] rom [512];
  assign bus.cs_word = rom[bus.cs_addr];

  typedef struct packed {
    logic [8:0] cs_addr;
    logic [8:0] c_en;
    logic [5:0] alu;
    logic [1:0] shift;
    logic [3:0] b_sel;
    logic [2:0] mem_op;
    logic       mem_req;
    logic       n;
    logic       z;
    logic       halted;
  } obs_t;

  obs_t expq[$];
  int   tests = 0;
  int   fails = 0;

  // Architectural model state
  logic [8:0]  pc;
  logic [35:0] mir;
  logic        nf, zf;

  function automatic logic r1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [7:0] r8();
    return 8'($urandom);
  endfunction

  function automatic logic [35:0] mkw(logic [8:0] a, logic jm, logic jn, logic jz,
                                      logic [1:0] sh, logic [5:0] al, logic [8:0] ce,
                                      logic [2:0] mm, logic [3:0] bs);
    return {a, jm, jn, jz, sh, al, ce, mm, bs};
  endfunction

  function automatic obs_t mk(logic [35:0] m, logic [8:0] a, logic ce_on, logic req,
                              logic n, logic z, logic h);
    obs_t o;
    o.cs_addr = a;
    o.c_en    = ce_on ? m[15:7] : 9'h000;
    o.alu     = m[21:16];
    o.shift   = m[23:22];
    o.b_sel   = m[3:0];
    o.mem_op  = m[6:4];
    o.mem_req = req;
    o.n       = n;
    o.z       = z;
    o.halted  = h;
    return o;
  endfunction

  function automatic logic [8:0] target(logic [35:0] w, logic n, logic z, logic [7:0] mb);
    int t;
    t = int'(w[35:27]);
    if ((w[25] && n) || (w[24] && z)) t = t | 256;
    if (w[26]) t = t | int'(mb);
    return 9'(t);
  endfunction

  task automatic model_reset();
    pc = 9'h000; mir = '0; nf = 1'b0; zf = 1'b0;
  endtask

  task automatic cyc(input obs_t e, input logic an, input logic az, input logic [7:0] mb,
                     input logic rdy, input logic rst);
    bus.alu_n = an; bus.alu_z = az; bus.mbr = mb; bus.mem_ready = rdy; reset = rst;
    expq.push_back(e);
    @(posedge clk); #1;
  endtask

  // One microinstruction: FETCH, EXEC, then kreq wait cycles if it touches memory.
  // rst_at > 0 asserts reset during that wait cycle and abandons the instruction.
  task automatic run_instr(input logic an, input logic az, input logic [7:0] mb,
                           input int kreq, input int rst_at);
    logic [35:0] w;
    logic        memop;
    int          k;
    w     = rom[pc];
    memop = (w[6:4] != 3'b000);
    k     = memop ? kreq : 0;
    cyc(mk(mir, pc, 1'b0, 1'b0, nf, zf, 1'b0), r1(), r1(), r8(), r1(), 1'b0);
    mir = w;
    cyc(mk(w, pc, 1'b1, memop, nf, zf, 1'b0), an, az, mb, memop ? (k == 0) : r1(), 1'b0);
    nf = an; zf = az; pc = target(w, an, az, mb);
    for (int j = 1; j <= k; j++) begin
      cyc(mk(w, pc, 1'b0, 1'b1, nf, zf, 1'b0), r1(), r1(), r8(), (j == k), (j == rst_at));
      if (j == rst_at) begin
        model_reset();
        return;
      end
    end
  endtask

  task automatic run_halt(input int h);
    cyc(mk(mir, pc, 1'b0, 1'b0, nf, zf, 1'b0), r1(), r1(), r8(), r1(), 1'b0);
    for (int i = 0; i < h; i++)
      cyc(mk(mir, pc, 1'b0, 1'b0, nf, zf, 1'b1), r1(), r1(), r8(), r1(), 1'b0);
    cyc(mk(mir, pc, 1'b0, 1'b0, nf, zf, 1'b1), r1(), r1(), r8(), r1(), 1'b1);
    model_reset();
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.cs_addr = bus.cs_addr;
    o.c_en    = bus.c_en;
    o.alu     = bus.alu_control;
    o.shift   = bus.shift;
    o.b_sel   = bus.b_sel;
    o.mem_op  = bus.mem_op;
    o.mem_req = bus.mem_req;
    o.n       = bus.n_flag;
    o.z       = bus.z_flag;
    o.halted  = bus.halted;
    return o;
  endfunction

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = sample();
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL cycle_out t=%0t got addr=%h c_en=%h alu=%h sh=%h bsel=%h mem_op=%h req=%b n=%b z=%b halt=%b want addr=%h c_en=%h alu=%h sh=%h bsel=%h mem_op=%h req=%b n=%b z=%b halt=%b",
                   $time, a.cs_addr, a.c_en, a.alu, a.shift, a.b_sel, a.mem_op, a.mem_req, a.n, a.z, a.halted,
                   e.cs_addr, e.c_en, e.alu, e.shift, e.b_sel, e.mem_op, e.mem_req, e.n, e.z, e.halted);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: run did not finish, got %0d tests want completion", tests);
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [35:0] w;
    for (int i = 0; i < 512; i++) rom[i] = {4'($urandom), $urandom};
    rom[9'h000] = mkw(9'h005, 1'b0, 1'b0, 1'b0, 2'b00, 6'h3C, 9'h001, 3'b000, 4'h0);
    rom[9'h005] = mkw(9'h010, 1'b0, 1'b0, 1'b1, 2'b01, 6'h11, 9'h0F0, 3'b000, 4'h3);
    rom[9'h110] = mkw(9'h005, 1'b0, 1'b0, 1'b0, 2'b10, 6'h22, 9'h10F, 3'b000, 4'h5);
    rom[9'h010] = mkw(9'h100, 1'b1, 1'b0, 1'b0, 2'b11, 6'h07, 9'h055, 3'b000, 4'h9);
    rom[9'h136] = mkw(9'h137, 1'b0, 1'b0, 1'b0, 2'b00, 6'h14, 9'h0AA, 3'b010, 4'h1);
    rom[9'h137] = mkw(9'h138, 1'b0, 1'b0, 1'b0, 2'b01, 6'h15, 9'h1AB, 3'b010, 4'h2);
    rom[9'h138] = mkw(9'h139, 1'b0, 1'b0, 1'b0, 2'b10, 6'h16, 9'h0CD, 3'b100, 4'h4);
    bus.alu_n = 1'b0; bus.alu_z = 1'b0; bus.mbr = 8'h00; bus.mem_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    run_instr(r1(), r1(), r8(), 0, 0);            // 000 -> 005
    run_instr(r1(), 1'b1, r8(), 0, 0);            // JAMZ taken -> 110
    run_instr(r1(), r1(), r8(), 0, 0);            // 110 -> 005
    run_instr(r1(), 1'b0, r8(), 0, 0);            // JAMZ not taken -> 010
    run_instr(r1(), r1(), 8'h36, 0, 0);           // JMPC dispatch -> 136
    run_instr(r1(), r1(), r8(), 3, 0);            // read, three wait cycles
    run_instr(r1(), r1(), r8(), 0, 0);            // read, ready in EXEC
    run_instr(r1(), r1(), r8(), 3, 1);            // reset in first wait cycle

    rom[9'h000] = mkw(9'h1FF, 1'b0, 1'b1, 1'b0, 2'b10, 6'h2A, 9'h1FF, 3'b001, 4'hA);
    rom[9'h1FF] = mkw(9'h123, 1'b1, 1'b1, 1'b1, 2'b01, 6'h3F, 9'h1FF, 3'b111, 4'h5);
    run_instr(r1(), r1(), r8(), 0, 0);
    run_halt(12);

    for (int i = 0; i < 512; i++) begin
      w = {4'($urandom), $urandom};
      if (r1()) w[6:4] = 3'b000;
      rom[i] = w;
    end
    for (int n = 0; n < 400; n++) begin
      if (pc == 9'h1FF) run_halt($urandom_range(1, 4));
      else run_instr(r1(), r1(), r8(), $urandom_range(0, 3),
                     ($urandom_range(0, 15) == 0) ? 1 : 0);
    end

    @(negedge clk);
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Mic-1 style microprogram sequencer. It drives the ALU, shifter, register-file enables and memory port from a 36-bit microinstruction register (MIR).
- It holds the micro-PC (MPC) and reads an external combinational control-store ROM.
- It computes the next address from the JAM bits, the ALU N/Z outputs and MBR, and stalls on memory requests.
- It sits between the control store and the datapath; alu, shifter and registers are controlled only through its outputs.

Parameters:
- RESET_ADDR, 9'h000, MPC value loaded on reset.
- HALT_ADDR, 9'h1FF, micro-address that stops sequencing.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cs_addr  out  9  control-store address; always equals MPC.
- cs_word  in  36  control-store data for cs_addr (combinational ROM).
- alu_n  in  1  ALU negative flag (n).
- alu_z  in  1  ALU zero flag (z).
- mbr  in  8  MBR low byte, used for JMPC dispatch.
- mem_ready  in  1  memory completed the requested operation.
- alu_control  out  ALU_CONTROL (6)  MIR ALU field.
- shift  out  2  {SLL8, SRA1} from MIR.
- c_en  out  9  C-bus register write enables, gated.
- b_sel  out  4  B-bus source select.
- mem_op  out  3  {WRITE, READ, FETCH} from MIR.
- mem_req  out  1  memory request strobe.
- n_flag  out  1  latched N.
- z_flag  out  1  latched Z.
- halted  out  1  sequencer stopped.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset; it is sampled only on the rising edge of clk.
- Reset values: state FETCH, MPC = RESET_ADDR, MIR = 0, n_flag = 0, z_flag = 0, halted = 0. All gated outputs are 0.
- Reset mid-operation (any state, including MEMW or HALT): returns to these values on the next edge. An outstanding memory request is dropped; mem_req is 0 in the cycle after reset.
- MIR layout, MSB to LSB:
  - [35:27] ADDR
  - [26] JMPC, [25] JAMN, [24] JAMZ
  - [23:22] shift
  - [21:16] alu_control
  - [15:7] c_en
  - [6:4] mem
  - [3:0] b_sel
- FSM states: FETCH, EXEC, MEMW, HALT.
- FETCH:
  - If MPC == HALT_ADDR: go to HALT. MIR is not loaded.
  - Otherwise: MIR <= cs_word; go to EXEC.
- EXEC (exactly one cycle):
  - c_en = MIR.c_en. In all other states c_en = 0.
  - n_flag <= alu_n and z_flag <= alu_z at the end of the cycle.
  - MPC <= next address, computed from the live alu_n, alu_z and mbr.
  - If MIR.mem != 0 and mem_ready = 0: go to MEMW. Otherwise go to FETCH.
- Next-address rule:
  - hi = ADDR[8] | (JAMN & alu_n) | (JAMZ & alu_z).
  - lo = ADDR[7:0] | (JMPC ? mbr : 8'h00).
  - next = {hi, lo}. Addresses wrap naturally at 9 bits.
- MEMW: c_en = 0. Hold MIR and MPC. Go to FETCH in the cycle in which mem_ready = 1 is sampled.
- mem_req: 1 iff (state == EXEC or MEMW) and MIR.mem != 0. mem_op is always MIR.mem.
- Memory handshake corner case: mem_ready already high during EXEC means no MEMW cycle is spent.
- HALT: halted = 1, all enables 0, mem_req = 0. The block stays in HALT until reset.
- Ungated outputs: alu_control, shift and b_sel are driven from MIR in every state.
- Latency: 2 cycles per microinstruction without memory stall; 2 + k cycles with k wait cycles.
- Multiple JAM bits may be set together; the OR rule applies unchanged.

Decomposition:
- definitions.svh holds: MPC_BITS = 9, MIR_BITS = 36, the MIR field offsets/widths, the mem bit positions, and the enum logic [1:0] seq_state_t {FETCH, EXEC, MEMW, HALT}.
- Sub-module next_address: purely combinational ADDR/JAM/N/Z/MBR to 9-bit next MPC. It is unit-testable on its own.

Test Plan:
- Reset release with ROM[0] = {ADDR=9'h005, ALU=6'h3C, c_en=9'h001, mem=0} -> cycle 1 FETCH: cs_addr = 0. Cycle 2 EXEC: c_en = 9'h001, alu_control = 6'h3C. Cycle 3: cs_addr = 9'h005.
- JAMZ test, ROM word ADDR=9'h010, JAMZ=1, run with alu_z=1 -> next MPC = 9'h110. Repeat with alu_z=0 -> 9'h010. z_flag follows alu_z.
- JMPC dispatch, ADDR=9'h100, JMPC=1, mbr=8'h36 -> next MPC = 9'h136.
- Memory stall, mem=3'b010 (READ), mem_ready low for 3 cycles then high -> mem_req high for 4 cycles (EXEC + 3 MEMW), c_en = 0 during MEMW, FETCH on the following edge. Repeat with mem_ready high in EXEC -> no MEMW cycle.
- Halt, ADDR=9'h1FF -> after that EXEC, halted = 1 and stays 1 for 10+ cycles; cs_word is never loaded; all enables 0.
- Reset asserted mid-MEMW -> next cycle: state FETCH, cs_addr = RESET_ADDR, mem_req = 0, n_flag = 0, z_flag = 0.
